// File: rtl/mdu_div_iter_pkg.sv
// Shared types and defaults for the iterative MDU divider.
package mdu_div_iter_pkg;

  localparam int DIV_WIDTH_DEF = 32;
  localparam int DIV_STEP_DEF  = 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Number of CALC cycles needed to retire all quotient bits.
  function automatic int div_iters(input int width, input int step);
    return width / step;
  endfunction

endpackage

// File: rtl/mdu_div_iter_step.sv
// Combinational core of the divider: STEP chained restoring shift/subtract
// stages on the partial remainder and the remaining dividend bits.
module mdu_div_iter_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH:0]   rem_cur,
  input  logic [WIDTH-1:0] dvd_cur,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_new,
  output logic [WIDTH-1:0] dvd_new,
  output logic [STEP-1:0]  qbits
);

  logic [WIDTH:0]   rem_v;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] dvd_v;
  logic             take;

  always_comb begin
    rem_v = rem_cur;
    dvd_v = dvd_cur;
    trial = '0;
    diff  = '0;
    take  = 1'b0;
    qbits = '0;
    for (int i = 0; i < STEP; i++) begin
      trial = {rem_v[WIDTH-1:0], dvd_v[WIDTH-1]};
      diff  = {1'b0, trial} - {2'b00, dvs};
      // A set remainder MSB means the true shifted value exceeds any divisor.
      take  = rem_v[WIDTH] | ~diff[WIDTH+1];
      rem_v = take ? diff[WIDTH:0] : trial;
      dvd_v = dvd_v << 1;
      qbits[STEP-1-i] = take;
    end
    rem_new = rem_v;
    dvd_new = dvd_v;
  end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative signed/unsigned divider shared by DIV and DIVU; returns
// {remainder, quotient} and holds it until the consumer acks.
module mdu_div_iter
  import mdu_div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int STEP  = DIV_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               div_valid_i,
  input  logic               div_signed_i,
  input  logic [WIDTH-1:0]   div_opr1_i,
  input  logic [WIDTH-1:0]   div_opr2_i,
  input  logic               div_ack_i,
  input  logic               div_flush_i,
  output logic               div_rdy_o,
  output logic               div_busy_o,
  output logic               div_ansok_o,
  output logic [2*WIDTH-1:0] div_data_o
);

  localparam int ITERS = div_iters(WIDTH, STEP);
  localparam int CNT_W = $clog2(ITERS + 1);

  div_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH:0]     rem_reg, rem_next, rem_step;
  logic [WIDTH-1:0]   dvd_reg, dvd_next, dvd_step;
  logic [WIDTH-1:0]   dvs_reg, dvs_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               dvs_zero_reg, dvs_zero_next;
  logic [2*WIDTH-1:0] data_reg, data_next;

  logic [STEP-1:0]    q_step;
  logic [WIDTH-1:0]   opr1_abs, opr2_abs, quo_fix, rem_fix;

  assign opr1_abs = (div_signed_i && div_opr1_i[WIDTH-1]) ? -div_opr1_i : div_opr1_i;
  assign opr2_abs = (div_signed_i && div_opr2_i[WIDTH-1]) ? -div_opr2_i : div_opr2_i;

  // Divide by zero already leaves |dividend| in the remainder, so only the
  // quotient needs forcing; re-applying the dividend sign restores it exactly.
  assign quo_fix = dvs_zero_reg ? '1 : (neg_q_reg ? -quo_reg : quo_reg);
  assign rem_fix = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

  mdu_div_iter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .rem_cur (rem_reg),
    .dvd_cur (dvd_reg),
    .dvs     (dvs_reg),
    .rem_new (rem_step),
    .dvd_new (dvd_step),
    .qbits   (q_step)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rem_next      = rem_reg;
    dvd_next      = dvd_reg;
    dvs_next      = dvs_reg;
    quo_next      = quo_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    dvs_zero_next = dvs_zero_reg;
    data_next     = data_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (div_valid_i) begin
          neg_q_next    = div_signed_i & (div_opr1_i[WIDTH-1] ^ div_opr2_i[WIDTH-1]);
          neg_r_next    = div_signed_i & div_opr1_i[WIDTH-1];
          dvs_zero_next = (div_opr2_i == '0);
          dvd_next      = opr1_abs;
          dvs_next      = opr2_abs;
          rem_next      = '0;
          quo_next      = '0;
          cnt_next      = CNT_W'(ITERS);
          state_next    = DIV_CALC;
        end
      end
      DIV_CALC: begin
        rem_next = rem_step;
        dvd_next = dvd_step;
        quo_next = (quo_reg << STEP) | WIDTH'(q_step);
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        data_next  = {rem_fix, quo_fix};
        state_next = DIV_DONE;
      end
      DIV_DONE: begin
        if (div_ack_i) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
    // Flush beats both a fresh request and a same-cycle ack.
    if (div_flush_i) begin
      state_next = DIV_IDLE;
      data_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= DIV_IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      quo_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dvs_zero_reg <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rem_reg      <= rem_next;
      dvd_reg      <= dvd_next;
      dvs_reg      <= dvs_next;
      quo_reg      <= quo_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      dvs_zero_reg <= dvs_zero_next;
      data_reg     <= data_next;
    end
  end

  assign div_rdy_o   = (state_reg == DIV_IDLE);
  assign div_busy_o  = (state_reg != DIV_IDLE);
  assign div_ansok_o = (state_reg == DIV_DONE);
  assign div_data_o  = data_reg;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Randomized self-checking bench for mdu_div_iter: a 32/1 and a 16/4 instance
// checked against a plain-arithmetic division model.
module tb_mdu_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        valid_a = 0, sgn_a = 0, ack_a = 0, flush_a = 0;
  logic [31:0] opr1_a = '0, opr2_a = '0;
  logic        rdy_a, busy_a, ansok_a;
  logic [63:0] data_a;

  logic        valid_b = 0, sgn_b = 0, ack_b = 0, flush_b = 0;
  logic [15:0] opr1_b = '0, opr2_b = '0;
  logic        rdy_b, busy_b, ansok_b;
  logic [31:0] data_b;

  int          n_total = 0;
  int          n_bad = 0;
  string       cur_op = "";
  logic [63:0] last_data;

  always #5 clk = ~clk;

  mdu_div_iter #(.WIDTH(32), .STEP(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .div_valid_i(valid_a), .div_signed_i(sgn_a),
    .div_opr1_i(opr1_a), .div_opr2_i(opr2_a), .div_ack_i(ack_a), .div_flush_i(flush_a),
    .div_rdy_o(rdy_a), .div_busy_o(busy_a), .div_ansok_o(ansok_a), .div_data_o(data_a)
  );

  mdu_div_iter #(.WIDTH(16), .STEP(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .div_valid_i(valid_b), .div_signed_i(sgn_b),
    .div_opr1_i(opr1_b), .div_opr2_i(opr2_b), .div_ack_i(ack_b), .div_flush_i(flush_b),
    .div_rdy_o(rdy_b), .div_busy_o(busy_b), .div_ansok_o(ansok_b), .div_data_o(data_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] got=%h exp=%h", tag, cur_op, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  task automatic ref_div(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res);
    logic [63:0] mask, ua, ub, q, r;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (ub == 64'd0) begin
      q = mask;
      r = ua;
    end else if (!sgn) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      sa = ua[w-1] ? $signed(ua - (mask + 64'd1)) : $signed(ua);
      sb = ub[w-1] ? $signed(ub - (mask + 64'd1)) : $signed(ub);
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end
    q = q & mask;
    r = r & mask;
    res = {r[31:0], q[31:0]};
  endtask

  function automatic logic get_ansok(input int inst);
    return (inst == 0) ? ansok_a : ansok_b;
  endfunction

  function automatic logic get_rdy(input int inst);
    return (inst == 0) ? rdy_a : rdy_b;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [63:0] get_data(input int inst);
    if (inst == 0) return data_a;
    return {16'd0, data_b[31:16], 16'd0, data_b[15:0]};
  endfunction

  task automatic set_ack(input int inst, input logic v);
    if (inst == 0) ack_a = v;
    else ack_b = v;
  endtask

  // Issues a request and waits (bounded) for ansok; lat counts edges from accept.
  task automatic start_and_wait(input int inst, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, output int lat);
    @(posedge clk); #1;
    if (inst == 0) begin
      sgn_a = sgn; opr1_a = a; opr2_a = b; valid_a = 1'b1;
    end else begin
      sgn_b = sgn; opr1_b = a[15:0]; opr2_b = b[15:0]; valid_b = 1'b1;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!get_ansok(inst) && lat < 100);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic do_div(input int inst, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] exp_d, got_d;
    int          lat, n;
    n = (inst == 0) ? 34 : 6;
    cur_op = $sformatf("u%0d s=%0d %h/%h", inst, sgn, a, b);
    ref_div((inst == 0) ? 32 : 16, sgn, a, b, exp_d);
    start_and_wait(inst, sgn, a, b, lat);
    got_d = get_data(inst);
    chk("latency", 64'(lat), 64'(n));
    chk("data", got_d, exp_d);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_ansok", {63'd0, get_ansok(inst)}, 64'd1);
      chk("hold_data", get_data(inst), exp_d);
    end
    set_ack(inst, 1'b1);
    @(posedge clk); #1;
    set_ack(inst, 1'b0);
    chk("ansok_drop", {63'd0, get_ansok(inst)}, 64'd0);
    chk("rdy_after_ack", {63'd0, get_rdy(inst)}, 64'd1);
    last_data = got_d;
    $display("op %s data=%h exp=%h lat=%0d", cur_op, got_d, exp_d, lat);
  endtask

  initial begin
    int          lat, cnt, k, inst;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    cur_op = "reset";
    chk("rst_rdy", {63'd0, rdy_a}, 64'd1);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_ansok", {63'd0, ansok_a}, 64'd0);
    chk("rst_data", data_a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned basic with a 5-cycle stall hold
    do_div(0, 1'b0, 32'd100, 32'd7, 5);
    chk("basic_const", last_data, {32'd2, 32'd14});

    // Signed sign matrix and overflow
    do_div(0, 1'b1, -32'sd7, 32'd2, 0);
    chk("neg_pos_const", last_data, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(0, 1'b1, 32'd7, -32'sd2, 1);
    do_div(0, 1'b1, -32'sd7, -32'sd2, 0);
    do_div(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("ovf_const", last_data, {32'd0, 32'h8000_0000});

    // Divide by zero
    do_div(0, 1'b0, 32'd5, 32'd0, 0);
    chk("divu0_const", last_data, {32'd5, 32'hFFFF_FFFF});
    do_div(0, 1'b1, -32'sd5, 32'd0, 0);
    chk("div0_const", last_data, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // Flush at CALC cycle 10, then a fresh 9/3
    cur_op = "flush_calc";
    @(posedge clk); #1;
    sgn_a = 1'b0; opr1_a = 32'd100; opr2_a = 32'd7; valid_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    valid_a = 1'b0;
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    chk("flush_rdy", {63'd0, rdy_a}, 64'd1);
    chk("flush_busy", {63'd0, busy_a}, 64'd0);
    chk("flush_data", data_a, 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ansok_a) cnt++;
    end
    chk("flush_no_ansok", 64'(cnt), 64'd0);
    do_div(0, 1'b0, 32'd9, 32'd3, 0);
    chk("after_flush_const", last_data, {32'd0, 32'd3});

    // Same-cycle ack and flush in DONE: flush wins
    cur_op = "ack_flush";
    start_and_wait(0, 1'b0, 32'd100, 32'd7, lat);
    ack_a = 1'b1;
    flush_a = 1'b1;
    @(posedge clk); #1;
    ack_a = 1'b0;
    flush_a = 1'b0;
    chk("ackflush_data", data_a, 64'd0);
    chk("ackflush_ansok", {63'd0, ansok_a}, 64'd0);
    $display("op %s lat=%0d", cur_op, lat);

    // Asynchronous reset while holding an answer
    cur_op = "reset_done";
    start_and_wait(0, 1'b1, -32'sd7, 32'd2, lat);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {63'd0, rdy_a}, 64'd1);
    chk("arst_busy", {63'd0, busy_a}, 64'd0);
    chk("arst_ansok", {63'd0, ansok_a}, 64'd0);
    chk("arst_data", data_a, 64'd0);
    $display("op %s lat=%0d", cur_op, lat);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized operands on both geometries
    for (int i = 0; i < 260; i++) begin
      inst = (i < 100) ? 0 : 1;
      ra = $urandom;
      rb = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) rb = 32'd0;
      else if (k == 1) rb = $urandom_range(1, 15);
      else if (k == 2) rb = -32'($urandom_range(1, 15));
      else if (k == 3) begin
        ra = (inst == 0) ? 32'h8000_0000 : 32'h0000_8000;
        rb = 32'hFFFF_FFFF;
      end else if (k == 4) ra = $urandom_range(0, 255);
      do_div(inst, 1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
    end

    // Idle instance must not have moved
    cur_op = "idle_b";
    chk("idle_b_busy", {63'd0, get_busy(1)}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_div_iter.md
# mdu_div_iter

Parametrised iterative signed/unsigned divider for the MDU. It is issued by the MDU stage that decodes DIV/DIVU, and it replaces the separate fixed-width div and divu cores with one shared engine. It retires `STEP` quotient bits per cycle and returns `{remainder, quotient}` for HI/LO writeback. It holds its answer under pipeline stall and aborts on flush.

## Interface
- `WIDTH`, 32: operand width; must be even, ≥ 4.
- `STEP`, 1: quotient bits per iteration; 1, 2 or 4; must divide `WIDTH`.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset. One clock only.
- `div_valid_i`  in  1: start request; accepted only when `div_rdy_o`=1.
- `div_signed_i`  in  1: 1 = DIV (two's complement), 0 = DIVU.
- `div_opr1_i`  in  `WIDTH`: dividend.
- `div_opr2_i`  in  `WIDTH`: divisor.
- `div_ack_i`  in  1: consumer has taken the answer (stage not stalled).
- `div_flush_i`  in  1: abort the current operation.
- `div_rdy_o`  out  1: engine idle; reset value 1.
- `div_busy_o`  out  1: operation accepted and not yet acked; reset value 0.
- `div_ansok_o`  out  1: answer valid, held until ack; reset value 0.
- `div_data_o`  out  2×`WIDTH`: `{remainder, quotient}`; reset value 0.

## Operation
- State machine: IDLE → CALC → FIX → DONE → IDLE.
- **IDLE**
  - `div_rdy_o`=1.
  - On `div_valid_i` & !`div_flush_i`: latch the sign flags.
  - Latch |dividend| and |divisor|. In signed mode, take the magnitude by negation when the MSB is set.
  - Clear the partial remainder. Load the iteration counter with `WIDTH/STEP`. Go to CALC.
- **CALC**
  - Each cycle the step sub-module performs `STEP` restoring shift/subtract steps on {rem, dividend}.
  - Decrement the counter. On the cycle where the counter reaches 1, go to FIX.
- **FIX**
  - Signed mode: quotient is negated iff the operand signs differ; remainder takes the sign of the dividend.
  - Result registers are written here. Go to DONE.
- **DONE**
  - `div_ansok_o`=1 and `div_data_o` is stable.
  - Stays in DONE while `div_ack_i`=0. This is the stall hold.
  - When `div_ack_i`=1: go to IDLE; `div_ansok_o` drops the next cycle.
- **Divide by zero:** quotient = all ones, remainder = original dividend, in both modes. There is no sign fix in this case. The full latency is still spent.
- **Signed overflow** (most-negative / −1): quotient = most-negative, remainder = 0. This falls out of the magnitude algorithm and must not be special-cased.
- **Flush**
  - `div_flush_i` in any state forces IDLE on the next edge, and overrides a same-cycle `div_valid_i`.
  - `div_data_o` is cleared to 0. `div_ansok_o` goes to 0.
- **Reset** mid-operation: immediate return to IDLE with all outputs at their reset values.
- `div_valid_i` outside IDLE is ignored. The issuing stage must keep its request high until ansok.
- **Width rule:** the partial remainder is `WIDTH+1` bits so that the subtract borrow is explicit. Outputs are exactly `WIDTH` bits each.

## Timing
- **Latency:** accept edge → `WIDTH/STEP` CALC edges → 1 FIX edge. `div_ansok_o` is high from `WIDTH/STEP + 2` cycles after the accept edge.
  - 34 cycles for `WIDTH`=32, `STEP`=1.
  - 10 cycles for `STEP`=4.
- **Throughput:** one operation per latency + 1 cycles when acked immediately. `div_rdy_o` rises the cycle after the ack edge.
- **Same-cycle ack and flush:** flush wins; the result is cleared.
- `div_busy_o` = state ≠ IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- State encodings (`DIV_IDLE`, `DIV_CALC`, `DIV_FIX`, `DIV_DONE`) and the default `WIDTH` go in `defines.v` beside the MDU op constants.
- Sub-module `div_iter_step`: purely combinational, parameterised by `WIDTH`/`STEP`. It performs `STEP` chained restoring subtract stages: (rem, dvd, dvs) → (rem', dvd', qbits).
- All registers use the project `DFFRE`-style async-reset flops. The enable comes from the FSM.

## Test plan
- **Unsigned basic, `WIDTH`=32, `STEP`=1:** 100 / 7 → data = {2, 14}. ansok exactly 34 cycles after accept, held 5 cycles with ack=0, drops 1 cycle after ack.
- **Signed sign matrix:** −7/2 → {−1, −3}; 7/−2 → {1, −3}; −7/−2 → {−1, 3}; 0x80000000/−1 → {0, 0x80000000}.
- **Divide by zero:** DIVU 5/0 → {5, 0xFFFFFFFF}; DIV −5/0 → {0xFFFFFFFB, 0xFFFFFFFF}. Latency unchanged.
- **Flush:** flush at CALC cycle 10 → IDLE next cycle, data 0, no ansok. A new 9/3 issued right after returns {0, 3}.
- **Reset:** `rst_n` low during DONE → rdy=1, ansok=0, data=0 asynchronously.
- **Parameter sweep:** `WIDTH`∈{8,16,32}, `STEP`∈{1,2,4}, 10k random operands. Compare against a reference model and check latency = `WIDTH/STEP`+2.
